pc_sequencer: RTL

Next-PC controller for the MIPS fetch stage. It owns the fetch PC register and picks its next value each cycle: sequential PC+4, a decode-stage jump (J/JAL/JR/JALR), an execute-stage taken branch, or a hold under stall. It drives the flush controls for the IF/ID and ID/EX pipeline registers, and enters a fault state on a misaligned redirect target.

---
 rtl/pc_seq_pkg.sv | 21 ++
 rtl/pc_sequencer_jump_target_calc.sv | 35 +++
 rtl/pc_sequencer.sv | 128 ++++++++++++
 3 files changed

// File: rtl/pc_seq_pkg.sv
// Shared constants and types for the fetch-stage next-PC sequencer.
package pc_seq_pkg;

  localparam logic [5:0]  OP_RTYPE          = 6'h00;
  localparam logic [5:0]  OP_J              = 6'h02;
  localparam logic [5:0]  OP_JAL            = 6'h03;
  localparam logic [5:0]  FN_JR             = 6'h08;
  localparam logic [5:0]  FN_JALR           = 6'h09;
  localparam logic [31:0] RESET_VEC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } seq_state_t;

  function automatic logic misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/pc_sequencer_jump_target_calc.sv
// Combinational jump decode (J/JAL/JR/JALR) with target and link-address computation.
module jump_target_calc
  import pc_seq_pkg::*;
(
  input  logic [31:0] ins,
  input  logic [31:0] pc_d,
  input  logic [31:0] rs_val,
  output logic        is_jump,
  output logic        is_reg_jump,
  output logic [31:0] target,
  output logic [31:0] link_addr
);

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        imm_jump;
  logic [31:0] pc_d_plus4;

  assign opcode     = ins[31:26];
  assign funct      = ins[5:0];
  assign pc_d_plus4 = pc_d + 32'd4;

  always_comb begin
    imm_jump    = (opcode == OP_J) || (opcode == OP_JAL);
    is_reg_jump = (opcode == OP_RTYPE) && ((funct == FN_JR) || (funct == FN_JALR));
    is_jump     = imm_jump || is_reg_jump;
    link_addr   = pc_d_plus4;
    if (is_reg_jump) begin
      target = rs_val;
    end else begin
      target = {pc_d_plus4[31:28], ins[25:0], 2'b00};
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC owner: picks branch / stall / jump / sequential next PC and drives pipeline flushes.
// Optional feature: define PC_SEQ_PERF_EN to add the saturating redirect_cnt output.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] RESET_VEC = RESET_VEC_DEFAULT
)(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic [31:0] ins,
  input  logic        ins_valid,
  input  logic [31:0] pc_d,
  input  logic [31:0] rs_val,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic [31:0] pc,
  output logic        fetch_en,
  output logic        flush_d,
  output logic        flush_e,
  output logic [31:0] link_addr,
  output logic        fault
`ifdef PC_SEQ_PERF_EN
  ,
  output logic [15:0] redirect_cnt
`endif
);

  seq_state_t  state_r;
  seq_state_t  next_state_s;
  logic [31:0] pc_r;
  logic [31:0] next_pc_s;
  logic        fault_r;
  logic        redirect_s;
  logic        is_jump_s;
  logic        is_reg_jump_s;
  logic [31:0] jump_target_s;

  jump_target_calc u_jump_target_calc (
    .ins         (ins),
    .pc_d        (pc_d),
    .rs_val      (rs_val),
    .is_jump     (is_jump_s),
    .is_reg_jump (is_reg_jump_s),
    .target      (jump_target_s),
    .link_addr   (link_addr)
  );

  // Priority next-PC selection; a misaligned redirect freezes pc and enters FAULT instead.
  always_comb begin
    next_state_s = state_r;
    next_pc_s    = pc_r;
    fetch_en     = 1'b0;
    flush_d      = 1'b0;
    flush_e      = 1'b0;
    redirect_s   = 1'b0;
    case (state_r)
      BOOT: begin
        next_state_s = RUN;
      end
      RUN: begin
        fetch_en = 1'b1;
        if (br_taken) begin
          flush_d = 1'b1;
          flush_e = 1'b1;
          if (misaligned(br_target)) begin
            next_state_s = FAULT;
          end else begin
            next_pc_s  = br_target;
            redirect_s = 1'b1;
          end
        end else if (stall) begin
          next_pc_s = pc_r;
        end else if (ins_valid && is_jump_s) begin
          flush_d = 1'b1;
          if (is_reg_jump_s && misaligned(jump_target_s)) begin
            next_state_s = FAULT;
          end else begin
            next_pc_s  = jump_target_s;
            redirect_s = 1'b1;
          end
        end else begin
          next_pc_s = pc_r + 32'd4;
        end
      end
      FAULT: begin
        flush_d = 1'b1;
      end
      default: begin
        next_state_s = BOOT;
      end
    endcase
  end

  // State, PC and sticky fault registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= BOOT;
      pc_r    <= RESET_VEC;
      fault_r <= 1'b0;
    end else begin
      state_r <= next_state_s;
      pc_r    <= next_pc_s;
      fault_r <= fault_r | (next_state_s == FAULT);
    end
  end

  assign pc    = pc_r;
  assign fault = fault_r;

`ifdef PC_SEQ_PERF_EN
  logic [15:0] redirect_cnt_r;

  // Saturating count of accepted branch/jump redirects.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect_cnt_r <= 16'd0;
    end else if (redirect_s && (redirect_cnt_r != 16'hFFFF)) begin
      redirect_cnt_r <= redirect_cnt_r + 16'd1;
    end else begin
      redirect_cnt_r <= redirect_cnt_r;
    end
  end

  assign redirect_cnt = redirect_cnt_r;
`endif

endmodule
